// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide, one result bit per cycle
//   Optional abort input enabled by defining MULDIV_ABORT_EN.
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   abort_i     (MULDIV_ABORT_EN only) cancel a running operation
//   start_i     launch operation, sampled only in IDLE
//   op_i        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a_i     multiplicand / dividend
//   src_b_i     multiplier / divisor
//   hi_o/lo_o   product high/low half, or remainder/quotient
//   busy_o      high in RUN and FINISH
//   done_o      one-cycle completion pulse
//   div_zero_o  high with done_o when a divide had a zero divisor
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
`ifdef MULDIV_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
    logic                 abort, sgn, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag, quo, rem;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   acc_nxt, prod;

`ifdef MULDIV_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign sgn   = ~op_i[0];
    assign a_neg = sgn & src_a_i[WIDTH-1];
    assign b_neg = sgn & src_b_i[WIDTH-1];
    assign a_mag = a_neg ? -src_a_i : src_a_i;
    assign b_mag = b_neg ? -src_b_i : src_b_i;

    // Multiply: upper half accumulates b_q, lower half holds the multiplier and shifts out.
    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
    assign acc_nxt   = is_div_q
                     ? (div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                         : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                     : {mul_sum, acc_q[WIDTH-1:1]};
    assign prod = neg_q ? -acc_nxt : acc_nxt;
    assign quo  = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    assign rem  = neg_rem_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE: if (start_i && !abort) begin
                is_div_d  = op_i[1];
                neg_d     = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                b_d       = op_i[1] ? b_mag : a_mag;
                acc_d     = {{WIDTH{1'b0}}, op_i[1] ? a_mag : b_mag};
                cnt_d     = CW'(WIDTH - 1);
                dz_d      = op_i[1] && (src_b_i == '0);
                state_d   = dz_d ? FINISH : RUN;
            end
            RUN: if (abort) begin
                state_d = IDLE;
            end else begin
                acc_d = acc_nxt;
                if (cnt_q == '0) begin
                    state_d = FINISH;
                    hi_d    = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
                    lo_d    = is_div_q ? quo : prod[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign busy_o     = state_q != IDLE;
    assign done_o     = state_q == FINISH;
    assign div_zero_o = done_o & dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 0, rst_n = 0, start = 0;
    logic [1:0]   op = 0;
    logic [W-1:0] a = 0, b = 0, hi, lo;
    logic         busy, done, dz;
`ifdef MULDIV_ABORT_EN
    logic         abort = 0;
`endif

    int passed = 0, total = 0;
    logic [W-1:0] exp_hi = 0, exp_lo = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
`ifdef MULDIV_ABORT_EN
        .abort_i(abort),
`endif
        .start_i(start), .op_i(op), .src_a_i(a), .src_b_i(b),
        .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done), .div_zero_o(dz)
    );

    always #5 clk = ~clk;

    // Reference: 64-bit language arithmetic; division truncates toward zero, % follows the dividend sign.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, y,
                                  inout logic [W-1:0] h, l, output logic z);
        longint sx = longint'($signed(x)), sy = longint'($signed(y));
        longint unsigned ux = 64'(x), uy = 64'(y);
        logic [63:0] r;
        z = 0;
        case (o)
            2'd0: begin r = 64'(sx * sy); h = r[63:32]; l = r[31:0]; end
            2'd1: begin r = ux * uy; h = r[63:32]; l = r[31:0]; end
            2'd2: if (y == 0) z = 1; else begin h = W'(sx % sy); l = W'(sx / sy); end
            default: if (y == 0) z = 1; else begin h = W'(ux % uy); l = W'(ux / uy); end
        endcase
    endfunction

    // Launches one operation once the unit is idle; n = edges from the start-sampling edge to done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, y, input int glitch,
                          output int n, output int busy_n);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin @(negedge clk); guard++; end
        op = o; a = x; b = y; start = 1;
        @(posedge clk); #1;
        start = 0; op = 2'($urandom); a = $urandom; b = $urandom;
        n = 1; busy_n = 0;
        while (!done && n < 100) begin
            if (busy) busy_n++;
            start = (n == glitch);
            @(posedge clk); #1;
            n++;
        end
        if (busy) busy_n++;
        start = 0;
    endtask

    task automatic test_reset;
        #23;
        total++;
        if ({busy, done, dz, hi, lo} !== '0) $display("FAIL reset: got %b %b %b %h %h want all zero", busy, done, dz, hi, lo);
        else passed++;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_directed;
        logic [1:0]   d_op[4] = '{2'd0, 2'd1, 2'd2, 2'd2};
        logic [W-1:0] d_a[4]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000};
        logic [W-1:0] d_b[4]  = '{32'h00000007, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        logic [W-1:0] d_hi[4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
        logic [W-1:0] d_lo[4] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'h80000000};
        int n, bn;
        for (int i = 0; i < 4; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], 0, n, bn);
            total++;
            if (n !== 33 || dz !== 1'b0) $display("FAIL directed%0d latency: got n=%0d dz=%b want n=33 dz=0", i, n, dz);
            else passed++;
            total++;
            if (hi !== d_hi[i] || lo !== d_lo[i]) $display("FAIL directed%0d result: got %h_%h want %h_%h", i, hi, lo, d_hi[i], d_lo[i]);
            else passed++;
            exp_hi = d_hi[i]; exp_lo = d_lo[i];
        end
    endtask

    task automatic test_div_zero;
        int n, bn;
        run_op(2'd1, 32'h80000001, 32'h2, 0, n, bn);
        total++;
        if (hi !== 1 || lo !== 2) $display("FAIL dz_setup: got %h_%h want 00000001_00000002", hi, lo);
        else passed++;
        run_op(2'd3, 32'd100, 32'd0, 0, n, bn);
        total++;
        if (n !== 1 || dz !== 1'b1 || bn !== 1) $display("FAIL dz_timing: got n=%0d dz=%b busy=%0d want 1 1 1", n, dz, bn);
        else passed++;
        total++;
        if (hi !== 1 || lo !== 2) $display("FAIL dz_hold: got %h_%h want 00000001_00000002", hi, lo);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) $display("FAIL dz_after: got busy=%b done=%b dz=%b want 0 0 0", busy, done, dz);
        else passed++;
        exp_hi = 1; exp_lo = 2;
    endtask

    task automatic test_restart;
        int n, bn;
        logic z;
        logic [W-1:0] x = $urandom, y = $urandom;
        model(2'd0, x, y, exp_hi, exp_lo, z);
        run_op(2'd0, x, y, 10, n, bn);
        total++;
        if (n !== 33 || bn !== 33 || hi !== exp_hi || lo !== exp_lo)
            $display("FAIL restart: got n=%0d busy=%0d %h_%h want 33 33 %h_%h", n, bn, hi, lo, exp_hi, exp_lo);
        else passed++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        op = 2'd1; a = 32'h12345678; b = 32'h9ABCDEF0; start = 1;
        @(posedge clk); #1; start = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        rst_n = 0; #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0)
            $display("FAIL reset_mid: got busy=%b done=%b %h_%h want 0 0 0_0", busy, done, hi, lo);
        else passed++;
        exp_hi = 0; exp_lo = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_random;
        int n, bn;
        logic z;
        logic [1:0] o;
        logic [W-1:0] x, y, sp[4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
            model(o, x, y, exp_hi, exp_lo, z);
            run_op(o, x, y, 0, n, bn);
            total++;
            if (n !== (z ? 1 : 33) || dz !== z || hi !== exp_hi || lo !== exp_lo)
                $display("FAIL random%0d op=%0d %h,%h: got n=%0d dz=%b %h_%h want n=%0d dz=%b %h_%h",
                         i, o, x, y, n, dz, hi, lo, z ? 1 : 33, z, exp_hi, exp_lo);
            else passed++;
        end
    endtask

`ifdef MULDIV_ABORT_EN
    task automatic test_abort;
        int n, bn;
        logic z, seen = 0;
        logic [W-1:0] x = $urandom, y = $urandom;
        @(negedge clk);
        while (busy) @(negedge clk);
        op = 2'd0; a = x; b = y; start = 1;
        @(posedge clk); #1; start = 0;
        for (int i = 1; i < 5; i++) begin @(posedge clk); #1; seen |= done; end
        abort = 1;
        @(posedge clk); #1; abort = 0; seen |= done;
        total++;
        if (busy !== 1'b0 || seen !== 1'b0 || hi !== exp_hi || lo !== exp_lo)
            $display("FAIL abort: got busy=%b done_seen=%b %h_%h want 0 0 %h_%h", busy, seen, hi, lo, exp_hi, exp_lo);
        else passed++;
        model(2'd1, y, x, exp_hi, exp_lo, z);
        op = 2'd1; a = y; b = x; start = 1;
        @(posedge clk); #1; start = 0; n = 1;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        total++;
        if (n !== 33 || hi !== exp_hi || lo !== exp_lo)
            $display("FAIL abort_restart: got n=%0d %h_%h want 33 %h_%h", n, hi, lo, exp_hi, exp_lo);
        else passed++;
        @(negedge clk); @(negedge clk);
        abort = 1; start = 1; op = 2'd0;
        @(posedge clk); #1; abort = 0; start = 0;
        total++;
        if (busy !== 1'b0) $display("FAIL abort_priority: got busy=%b want 0", busy);
        else passed++;
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_div_zero;
        test_restart;
        test_reset_mid;
        test_random;
`ifdef MULDIV_ABORT_EN
        test_abort;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit.
- Replaces the separate fixed 32-bit mult and div blocks in the multicycle CPU with a single shared datapath.
- Supports signed and unsigned multiply and divide, one result bit per cycle, with a start/done handshake to the control unit.
- Results feed the HI/LO select muxes: hi_out = product high half or remainder; lo_out = product low half or quotient.

Parameters:
WIDTH, 32, operand width in bits; legal range 4..64.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU
src_a  input  WIDTH  multiplicand / dividend
src_b  input  WIDTH  multiplier / divisor
hi_out  output  WIDTH  product[2*WIDTH-1:WIDTH] or remainder
lo_out  output  WIDTH  product[WIDTH-1:0] or quotient
busy  output  1  high from the edge after start is accepted until done falls
done  output  1  single-cycle completion pulse
div_zero  output  1  high together with done when a DIV/DIVU had src_b == 0

Behaviour:
- Reset (reset == 0, asynchronous): FSM to IDLE; hi_out, lo_out, internal accumulators and counter cleared to 0; busy, done and div_zero forced to 0.
- FSM states:
  - IDLE:
    - start = 1: latch op, src_a and src_b.
    - Signed ops: store operand magnitudes plus result-sign flags.
    - Divisor == 0 on DIV/DIVU: go to FINISH with zero flag set.
    - Otherwise go to RUN with counter = WIDTH-1.
  - RUN: one iteration per cycle; at counter == 0 go to FINISH; otherwise decrement.
    - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
    - Divide: restoring division on magnitudes.
  - FINISH: one cycle, then back to IDLE.
    - done = 1.
    - hi_out/lo_out updated on entry to FINISH and held until the next FINISH or reset.
    - Divide-by-zero: hi_out/lo_out keep their previous values and div_zero = 1.
- Latency:
  - Normal operation: done is high in the cycle after WIDTH+1 rising edges, counting from the edge that samples start.
  - Divide by zero: done is high after 1 edge.
- Handshake:
  - start while busy or in FINISH is ignored.
  - src_a, src_b and op changes after acceptance have no effect.
  - start may be reasserted in the cycle after done; it is accepted because the FSM is back in IDLE.
- Sign rules:
  - MULT: product negated if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Results are truncated to WIDTH bits with wrap-around: the most-negative value / -1 gives quotient = most-negative and remainder = 0, with no flag.
- Unsigned ops: operands treated as raw WIDTH-bit magnitudes.
- busy is low in IDLE and high in RUN and FINISH.

Optional Feature:
- Macro MULDIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort = 1 in RUN returns the FSM to IDLE on the next edge.
  - No done pulse; hi_out/lo_out unchanged.
  - abort in IDLE or FINISH is ignored; abort and start together in IDLE gives abort priority, so start is not accepted.
- Undefined: no abort port; every accepted operation runs to completion.

Test Plan:
- MULT, src_a = 0xFFFFFFFD, src_b = 0x00000007 -> done exactly 33 edges after start; hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB; div_zero = 0.
- MULTU, 0xFFFFFFFF x 0xFFFFFFFF -> hi_out = 0xFFFFFFFE, lo_out = 0x00000001.
- DIV, 0xFFFFFFF9 / 0x00000002 -> lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF.
- DIV, 0x80000000 / 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0x00000000.
- DIVU, 100 / 0 after a prior result of hi = 1, lo = 2 -> done one edge after start with div_zero = 1; hi_out = 1 and lo_out = 2 unchanged; busy high for exactly 1 cycle.
- Robustness, in sequence:
  - Pulse start again mid-RUN -> ignored; the original result is produced.
  - Drive reset low at RUN cycle 10 -> busy, done, hi_out and lo_out go to 0 immediately.
  - With MULDIV_ABORT_EN defined, abort at RUN cycle 5 -> no done pulse; hi_out/lo_out unchanged; a new start is accepted on the following cycle.
